pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the IF/ID pipeline register and the stages around it.
- Detects load-use hazards from the fields decoded out of IF/ID (Rn, Rm, Rd) against the load in EX.
- Handles taken-branch flushes, and freezes the pipe while data memory is busy.
- Drives PC load-enable, IF/ID load-enable and clear, ID/EX bubble insert, and EX/MEM enable.
- Keeps a stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/hazard_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the IF/ID pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned RegIdxW = 4;
  localparam logic [RegIdxW-1:0] PcRegIdx = 4'd15;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StMemWait = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: ID source fields against the destination of a load sitting in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic               ex_load_i,
  input  logic [RegIdxW-1:0] ex_rd_i,
  input  logic [RegIdxW-1:0] id_rn_i,
  input  logic [RegIdxW-1:0] id_rm_i,
  input  logic [RegIdxW-1:0] id_rd_i,
  input  logic               id_use_rn_i,
  input  logic               id_use_rm_i,
  input  logic               id_use_rd_i,
  output logic               hazard_o
);

  always_comb begin
    hazard_o = ex_load_i & ((id_use_rn_i & (id_rn_i == ex_rd_i)) |
                            (id_use_rm_i & (id_rm_i == ex_rd_i)) |
                            (id_use_rd_i & (id_rd_i == ex_rd_i)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID sequencing controller: load-use bubbles, taken-branch flushes, memory-busy freeze,
// plus a saturating stall counter and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic [RegIdxW-1:0]     ID_Rn,
  input  logic [RegIdxW-1:0]     ID_Rm,
  input  logic [RegIdxW-1:0]     ID_Rd,
  input  logic                   ID_Use_Rn,
  input  logic                   ID_Use_Rm,
  input  logic                   ID_Use_Rd,
  input  logic                   EX_Load,
  input  logic [RegIdxW-1:0]     EX_Rd,
  input  logic                   Branch_Taken,
  input  logic                   MEM_Busy,
  output logic                   PC_LE,
  output logic                   IFID_LE,
  output logic                   IFID_CLR,
  output logic                   IDEX_Bubble,
  output logic                   EXMEM_LE,
  output logic [STALL_CNT_W-1:0] Stall_Count,
  output logic                   Mem_Error
);

  localparam logic [9:0] MemTimeout = 10'(MEM_TIMEOUT);
  localparam logic [2:0] FlushInit  = 3'(FLUSH_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [2:0]             flush_q, flush_d;
  logic [9:0]             busy_q, busy_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   err_q, err_d;
  logic                   hazard;

  hazard_detect u_hazard_detect (
    .ex_load_i   (EX_Load),
    .ex_rd_i     (EX_Rd),
    .id_rn_i     (ID_Rn),
    .id_rm_i     (ID_Rm),
    .id_rd_i     (ID_Rd),
    .id_use_rn_i (ID_Use_Rn),
    .id_use_rm_i (ID_Use_Rm),
    .id_use_rd_i (ID_Use_Rd),
    .hazard_o    (hazard)
  );

  always_comb begin
    PC_LE       = 1'b1;
    IFID_LE     = 1'b1;
    IFID_CLR    = 1'b0;
    IDEX_Bubble = 1'b0;
    EXMEM_LE    = 1'b1;
    state_d     = state_q;
    flush_d     = flush_q;
    busy_d      = busy_q;
    err_d       = err_q;
    stall_d     = stall_q;

    if (CLR) begin
      PC_LE       = 1'b0;
      IFID_LE     = 1'b0;
      IFID_CLR    = 1'b1;
      IDEX_Bubble = 1'b1;
      EXMEM_LE    = 1'b0;
    end else if (MEM_Busy) begin
      // Full freeze in every state; only the wait bookkeeping moves.
      PC_LE    = 1'b0;
      IFID_LE  = 1'b0;
      EXMEM_LE = 1'b0;
      unique case (state_q)
        StRun: begin
          busy_d  = 10'd1;
          state_d = StMemWait;
        end
        StMemWait: begin
          if (busy_q < MemTimeout) begin
            busy_d = busy_q + 10'd1;
          end
          if (busy_d >= MemTimeout) begin
            err_d = 1'b1;
          end
        end
        StFlush: ;
        default: state_d = StRun;
      endcase
    end else begin
      unique case (state_q)
        StFlush: begin
          // ID holds a NOP here, so hazard and Branch_Taken are not looked at.
          IFID_CLR = 1'b1;
          flush_d  = flush_q - 3'd1;
          if (flush_q <= 3'd1) begin
            state_d = StRun;
          end
        end
        StRun, StMemWait: begin
          busy_d  = 10'd0;
          state_d = StRun;
          if (hazard) begin
            PC_LE       = 1'b0;
            IFID_LE     = 1'b0;
            IDEX_Bubble = 1'b1;
          end else if (Branch_Taken) begin
            IFID_CLR = 1'b1;
            flush_d  = FlushInit;
            state_d  = (FLUSH_CYCLES > 1) ? StFlush : StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end

    if (!CLR && !PC_LE && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= StRun;
      flush_q <= 3'd0;
      busy_q  <= 10'd0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign Stall_Count = stall_q;
  assign Mem_Error   = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: driver queues expected per-cycle responses,
// an independent monitor pops and compares them on the falling edge.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic [3:0]  ID_Rn = '0, ID_Rm = '0, ID_Rd = '0, EX_Rd = '0;
  logic        ID_Use_Rn = 0, ID_Use_Rm = 0, ID_Use_Rd = 0;
  logic        EX_Load = 0, Branch_Taken = 0, MEM_Busy = 0;
  logic        PC_LE, IFID_LE, IFID_CLR, IDEX_Bubble, EXMEM_LE, Mem_Error;
  logic [15:0] Stall_Count;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (4),
    .STALL_CNT_W  (16)
  ) dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .ID_Rn        (ID_Rn),
    .ID_Rm        (ID_Rm),
    .ID_Rd        (ID_Rd),
    .ID_Use_Rn    (ID_Use_Rn),
    .ID_Use_Rm    (ID_Use_Rm),
    .ID_Use_Rd    (ID_Use_Rd),
    .EX_Load      (EX_Load),
    .EX_Rd        (EX_Rd),
    .Branch_Taken (Branch_Taken),
    .MEM_Busy     (MEM_Busy),
    .PC_LE        (PC_LE),
    .IFID_LE      (IFID_LE),
    .IFID_CLR     (IFID_CLR),
    .IDEX_Bubble  (IDEX_Bubble),
    .EXMEM_LE     (EXMEM_LE),
    .Stall_Count  (Stall_Count),
    .Mem_Error    (Mem_Error)
  );

  typedef struct {
    int          idx;
    logic [4:0]  ctrl;   // {PC_LE, IFID_LE, IFID_CLR, IDEX_Bubble, EXMEM_LE}
    logic [15:0] stall;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t       e;
      logic [4:0] act;
      e   = exp_q.pop_front();
      act = {PC_LE, IFID_LE, IFID_CLR, IDEX_Bubble, EXMEM_LE};
      n_checks++;
      if (act === e.ctrl) n_pass++;
      else $display("FAIL ctrl step %0d: got %b want %b", e.idx, act, e.ctrl);
      n_checks++;
      if (Stall_Count === e.stall) n_pass++;
      else $display("FAIL stall step %0d: got %0d want %0d", e.idx, Stall_Count, e.stall);
      n_checks++;
      if (Mem_Error === e.err) n_pass++;
      else $display("FAIL mem_error step %0d: got %b want %b", e.idx, Mem_Error, e.err);
    end
  end

  // Vector: clr, ex_load, ex_rd, rn, urn, rm, urm, rd, urd, br, busy | ctrl, stall, err
  typedef struct {
    logic       clr, ld;
    logic [3:0] exrd, rn;
    logic       urn;
    logic [3:0] rm;
    logic       urm;
    logic [3:0] rd;
    logic       urd, br, busy;
    logic [4:0] ctrl;
    int         stall;
    logic       err;
  } vec_t;

  localparam logic [4:0] Run = 5'b11001, Bub = 5'b00011, Clr = 5'b11101;
  localparam logic [4:0] Frz = 5'b00000, Rst = 5'b00110;

  vec_t vecs[$];

  task automatic add(input logic clr, ld, input logic [3:0] exrd, rn, input logic urn,
                     input logic [3:0] rm, input logic urm, input logic [3:0] rd,
                     input logic urd, br, busy, input logic [4:0] ctrl, input int stall,
                     input logic err);
    vec_t v;
    v = '{clr, ld, exrd, rn, urn, rm, urm, rd, urd, br, busy, ctrl, stall, err};
    vecs.push_back(v);
  endtask

  initial begin
    //   clr ld exrd rn urn rm urm rd urd br busy  ctrl stall err
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Rst, 0, 0);  // reset state
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Run, 0, 0);
    add(0, 1, 3, 3, 1, 0, 0, 0, 0, 0, 0, Bub, 0, 0);  // load-use on Rn
    add(0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, Run, 1, 0);
    add(0, 1, 3, 5, 1, 3, 0, 0, 0, 0, 0, Run, 1, 0);  // Rm matches but unused
    add(0, 1, 7, 0, 0, 0, 0, 7, 1, 0, 0, Bub, 1, 0);  // store-data Rd hazard
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, Clr, 2, 0);  // branch -> FLUSH
    add(0, 1, 3, 3, 1, 0, 0, 0, 0, 1, 0, Clr, 2, 0);  // FLUSH ignores br/hazard
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Run, 2, 0);
    add(0, 1, 3, 3, 1, 0, 0, 0, 0, 1, 0, Bub, 2, 0);  // hazard beats branch
    add(0, 0, 3, 3, 1, 0, 0, 0, 0, 1, 0, Clr, 3, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Clr, 3, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Frz, 3, 0);  // busy x5, timeout 4
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Frz, 4, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Frz, 5, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Frz, 6, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Frz, 7, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Run, 8, 1);  // sticky error
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Run, 8, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, Clr, 8, 1);  // branch -> FLUSH
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Frz, 8, 1);  // busy freezes FLUSH
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, Clr, 9, 1);  // resumes, br ignored
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Run, 9, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Frz, 9, 1);
    add(0, 1, 2, 0, 0, 2, 1, 0, 0, 0, 0, Bub, 10, 1); // MEM_WAIT exit acts as RUN
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Run, 11, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, Clr, 11, 1); // branch -> FLUSH
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Rst, 11, 1); // reset mid-flush
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Run, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Run, 0, 0);

    repeat (2) @(posedge CLK);
    foreach (vecs[i]) begin
      exp_t e;
      #1;
      CLR = vecs[i].clr;  EX_Load = vecs[i].ld;  EX_Rd = vecs[i].exrd;
      ID_Rn = vecs[i].rn; ID_Use_Rn = vecs[i].urn;
      ID_Rm = vecs[i].rm; ID_Use_Rm = vecs[i].urm;
      ID_Rd = vecs[i].rd; ID_Use_Rd = vecs[i].urd;
      Branch_Taken = vecs[i].br; MEM_Busy = vecs[i].busy;
      e.idx   = i;
      e.ctrl  = vecs[i].ctrl;
      e.stall = 16'(vecs[i].stall);
      e.err   = vecs[i].err;
      exp_q.push_back(e);
      @(posedge CLK);
    end

    repeat (3) @(posedge CLK);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
